// File: rtl/gate_pair_monitor.sv
// Gate-pair monitor: measures dead time between complementary gate
// feedbacks, flags short gaps and shoot-through, rebuilds the PWM.
module gate_pair_monitor #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   gate_fb,
  input  logic [N-1:0] min_dead_clks,
  input  logic         clear_fault,
  output logic [N-1:0] dt_hs_ls,
  output logic [N-1:0] dt_ls_hs,
  output logic [1:0]   dt_valid,
  output logic         dead_time_violation,
  output logic         shoot_through,
  output logic         pwm_rec
);

  typedef enum logic [2:0] {
    IDLE,
    HS_ON,
    LS_ON,
    GAP_HS,
    GAP_LS,
    FAULT
  } state_t;

  logic [1:0]   s1;
  logic [1:0]   s;
  state_t       st;
  state_t       st_nx;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nx;
  logic [N-1:0] cnt_inc;
  logic [N-1:0] meas;
  logic [1:0]   strb;
  logic         st_set;
  logic         vio_set;
  logic         leave_fault;
  logic         pwm_nx;

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_comb begin
    st_nx  = st;
    cnt_nx = '0;
    meas   = '0;
    strb   = 2'b00;
    st_set = 1'b0;
    if (st != FAULT && s == 2'b11) begin
      st_nx  = FAULT;
      st_set = 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (s == 2'b01)      st_nx = HS_ON;
          else if (s == 2'b10) st_nx = LS_ON;
        end
        HS_ON: begin
          if (s == 2'b00) begin
            st_nx  = GAP_HS;
            cnt_nx = N'(1);
          end else if (s == 2'b10) begin
            st_nx = LS_ON;
            strb  = 2'b01;
          end
        end
        LS_ON: begin
          if (s == 2'b00) begin
            st_nx  = GAP_LS;
            cnt_nx = N'(1);
          end else if (s == 2'b01) begin
            st_nx = HS_ON;
            strb  = 2'b10;
          end
        end
        GAP_HS: begin
          if (s == 2'b00) begin
            cnt_nx = cnt_inc;
          end else if (s == 2'b10) begin
            st_nx = LS_ON;
            meas  = cnt;
            strb  = 2'b01;
          end else begin
            st_nx = HS_ON;
          end
        end
        GAP_LS: begin
          if (s == 2'b00) begin
            cnt_nx = cnt_inc;
          end else if (s == 2'b01) begin
            st_nx = HS_ON;
            meas  = cnt;
            strb  = 2'b10;
          end else begin
            st_nx = LS_ON;
          end
        end
        FAULT: begin
          if (clear_fault && s == 2'b00) st_nx = IDLE;
        end
        default: st_nx = IDLE;
      endcase
    end
  end

  assign vio_set     = (strb != 2'b00) && (meas < min_dead_clks);
  assign leave_fault = (st == FAULT) && (st_nx == IDLE);

  always_comb begin
    pwm_nx = 1'b0;
    case (st_nx)
      HS_ON, GAP_HS: pwm_nx = 1'b1;
      FAULT:         pwm_nx = pwm_rec;
      default:       pwm_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1                  <= 2'b00;
      s                   <= 2'b00;
      st                  <= IDLE;
      cnt                 <= '0;
      dt_hs_ls            <= '0;
      dt_ls_hs            <= '0;
      dt_valid            <= 2'b00;
      dead_time_violation <= 1'b0;
      shoot_through       <= 1'b0;
      pwm_rec             <= 1'b0;
    end else begin
      s1       <= gate_fb;
      s        <= s1;
      st       <= st_nx;
      cnt      <= cnt_nx;
      dt_valid <= strb;
      pwm_rec  <= pwm_nx;
      if (strb[0]) dt_hs_ls <= meas;
      if (strb[1]) dt_ls_hs <= meas;
      // set wins over a coincident clear
      if (vio_set)
        dead_time_violation <= 1'b1;
      else if (clear_fault && (st != FAULT || leave_fault))
        dead_time_violation <= 1'b0;
      if (st_set)
        shoot_through <= 1'b1;
      else if (leave_fault)
        shoot_through <= 1'b0;
    end
  end

endmodule
